// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I fetch constants
package rv32i_pkg;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam int          EXP_INST_MISALIGN = 0;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH x W FIFO with flush taking priority over push/pop
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wptr_d  = flush ? '0 : wptr_q + AW'(push);
    rptr_d  = flush ? '0 : rptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
    if (push && !flush) mem_q[wptr_q] <= wdata;
  end
  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: in-order instruction fetch over req/gnt/rvalid with credit-limited buffering
// and redirect flush that discards stale in-flight responses.
module inst_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_exp
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d, rdata;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic          hold_q, hold_d, empty, full, fire, push, pop;
  always_comb begin
    imem_req   = !rst && !redirect_valid && !hold_q &&
                 ({1'b0, out_q} + {1'b0, count} < (CW+1)'(DEPTH));
    fire       = imem_req && imem_gnt;
    pop        = !empty && !stall && !redirect_valid;
    push       = imem_rvalid && drop_q == '0 && !redirect_valid && (!full || pop);
    out_d      = out_q + CW'(fire) - CW'(imem_rvalid);
    // after a redirect every word still in flight is stale, including earlier stale ones
    drop_d     = redirect_valid ? out_q - CW'(imem_rvalid)
                                : drop_q - CW'(imem_rvalid && drop_q != '0);
    fetch_pc_d = redirect_valid ? redirect_pc : fetch_pc_q + (fire ? 32'd4 : 32'd0);
    head_pc_d  = redirect_valid ? redirect_pc : head_pc_q + (pop ? 32'd4 : 32'd0);
    hold_d     = redirect_valid ? |redirect_pc[1:0] : hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      hold_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      hold_q     <= hold_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (imem_rdata),
    .rdata (rdata),
    .count (count),
    .empty (empty),
    .full  (full)
  );
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = hold_q || !empty;
  assign inst       = hold_q ? NOP : rdata;
  assign inst_pc    = head_pc_q;
  assign fetch_exp  = hold_q;
endmodule
